// File: rtl/video_timing_pkg.sv
// Video timing descriptors, presets and FSM state encodings shared by
// the raster counter and the stream-to-video bridge.
package video_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_front;
        logic [15:0] h_sync;
        logic [15:0] h_back;
        logic [15:0] v_active;
        logic [15:0] v_front;
        logic [15:0] v_sync;
        logic [15:0] v_back;
    } video_timing_t;

    localparam video_timing_t TIMING_1280X720_60 = '{
        h_active: 16'd1280, h_front: 16'd110, h_sync: 16'd40, h_back: 16'd220,
        v_active: 16'd720,  v_front: 16'd5,   v_sync: 16'd5,  v_back: 16'd20
    };

    localparam video_timing_t TIMING_640X480_60 = '{
        h_active: 16'd640, h_front: 16'd16, h_sync: 16'd96, h_back: 16'd48,
        v_active: 16'd480, v_front: 16'd10, v_sync: 16'd2,  v_back: 16'd33
    };

    localparam logic [1:0] ST_SEEK   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    function automatic int unsigned timing_total(input video_timing_t t,
                                                 input logic vertical);
        if (vertical)
            return 32'(t.v_active) + 32'(t.v_front)
                 + 32'(t.v_sync) + 32'(t.v_back);
        return 32'(t.h_active) + 32'(t.h_front)
             + 32'(t.h_sync) + 32'(t.h_back);
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Free-running h/v raster counters with active-area and raw
// (active-high) sync decode.
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter video_timing_t TIMING = TIMING_1280X720_60,
    parameter int HW = $clog2(timing_total(TIMING, 1'b0)),
    parameter int VW = $clog2(timing_total(TIMING, 1'b1))
) (
    input  logic          clock,
    input  logic          reset,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          active,
    output logic          hsync,
    output logic          vsync
);

    localparam int unsigned H_TOTAL = timing_total(TIMING, 1'b0);
    localparam int unsigned V_TOTAL = timing_total(TIMING, 1'b1);
    localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_END = VW'(V_TOTAL - 1);

    localparam int unsigned HA  = 32'(TIMING.h_active);
    localparam int unsigned VA  = 32'(TIMING.v_active);
    localparam int unsigned HS0 = HA + 32'(TIMING.h_front);
    localparam int unsigned HS1 = HS0 + 32'(TIMING.h_sync);
    localparam int unsigned VS0 = VA + 32'(TIMING.v_front);
    localparam int unsigned VS1 = VS0 + 32'(TIMING.v_sync);

    logic [31:0] h_wide;
    logic [31:0] v_wide;

    always_ff @(posedge clock) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_END) begin
            h <= '0;
            v <= (v == V_END) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Widened copies keep sync bounds exact even when a window ends at the total
    assign h_wide = 32'(h);
    assign v_wide = 32'(v);

    assign active = (h_wide < HA) && (v_wide < VA);
    assign hsync  = (h_wide >= HS0) && (h_wide < HS1);
    assign vsync  = (v_wide >= VS0) && (v_wide < VS1);

endmodule

// File: rtl/stream_to_video.sv
// Locks an SOF/EOL framed valid/ready pixel stream onto a free-running
// raster and drives registered DE/sync/RGB for the DVI encoder.
module stream_to_video
    import video_timing_pkg::*;
#(
    parameter int          H_ACTIVE   = 1280,
    parameter int          H_FRONT    = 110,
    parameter int          H_SYNC     = 40,
    parameter int          H_BACK     = 220,
    parameter int          V_ACTIVE   = 720,
    parameter int          V_FRONT    = 5,
    parameter int          V_SYNC     = 5,
    parameter int          V_BACK     = 20,
    parameter logic        SYNC_POL   = 1'b1,
    parameter logic [23:0] FILL_COLOR = 24'h000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic [23:0] pixel_data,
    input  logic        pixel_user,
    input  logic        pixel_last,
    output logic        video_de,
    output logic        video_hsync,
    output logic        video_vsync,
    output logic [23:0] video_data,
    output logic        locked,
    output logic        underflow
);

    localparam video_timing_t TIMING = '{
        h_active: 16'(H_ACTIVE), h_front: 16'(H_FRONT),
        h_sync:   16'(H_SYNC),   h_back:  16'(H_BACK),
        v_active: 16'(V_ACTIVE), v_front: 16'(V_FRONT),
        v_sync:   16'(V_SYNC),   v_back:  16'(V_BACK)
    };
    localparam int HW = $clog2(timing_total(TIMING, 1'b0));
    localparam int VW = $clog2(timing_total(TIMING, 1'b1));
    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active;
    logic          hs;
    logic          vs;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       at_origin;
    logic       line_end;
    logic       frame_end;
    logic       taking;
    logic       framing_err;
    logic       drop_lock;

    video_timing_counter #(
        .TIMING (TIMING),
        .HW     (HW),
        .VW     (VW)
    ) u_timing (
        .clock  (clock),
        .reset  (reset),
        .h      (h),
        .v      (v),
        .active (active),
        .hsync  (hs),
        .vsync  (vs)
    );

    assign at_origin = (h == '0) && (v == '0);
    assign line_end  = (h == H_LAST);
    assign frame_end = line_end && (v == V_LAST);

    // ARMED hands its held SOF beat over exactly at the origin
    assign taking = (state == ST_STREAM)
                 || ((state == ST_ARMED) && at_origin);

    assign framing_err = (pixel_last != line_end)
                      || (pixel_user && !at_origin);

    always_comb begin
        pixel_ready = 1'b1;
        if (!reset) begin
            unique case (state)
                ST_SEEK:   pixel_ready = !(pixel_valid && pixel_user);
                ST_ARMED:  pixel_ready = at_origin;
                ST_STREAM: pixel_ready = active;
                default:   pixel_ready = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        drop_lock  = 1'b0;
        unique case (state)
            ST_SEEK:  if (pixel_valid && pixel_user) state_next = ST_ARMED;
            ST_FLUSH: if (at_origin) state_next = ST_SEEK;
            default:  ;
        endcase
        if (taking && active) begin
            if (!pixel_valid || framing_err) begin
                drop_lock  = 1'b1;
                state_next = ST_FLUSH;
            end else if (frame_end) begin
                state_next = ST_SEEK;
            end else begin
                state_next = ST_STREAM;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_SEEK;
            video_de    <= 1'b0;
            video_hsync <= !SYNC_POL;
            video_vsync <= !SYNC_POL;
            video_data  <= '0;
            underflow   <= 1'b0;
        end else begin
            state       <= state_next;
            video_de    <= active;
            video_hsync <= !(hs ^ SYNC_POL);
            video_vsync <= !(vs ^ SYNC_POL);
            underflow   <= drop_lock;
            if (!active)
                video_data <= '0;
            else if (taking && pixel_valid)
                video_data <= pixel_data;
            else
                video_data <= FILL_COLOR;
        end
    end

    assign locked = (state == ST_STREAM);

endmodule
